// File: rtl/dmem_access_ctrl_if.sv
// Data-memory request/response bus between the access controller (master)
// and the handshaked data memory (slave).
interface dmem_access_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_done;

  modport master (
    output mem_rd, mem_wr, mem_addr, mem_wdata,
    input  mem_rdata, mem_done
  );

  modport slave (
    input  mem_rd, mem_wr, mem_addr, mem_wdata,
    output mem_rdata, mem_done
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer for the EX/MEM instruction. It issues a
// single-cycle read or write request, freezes the front pipeline until the
// memory answers (or a timeout aborts the attempt), then releases the
// pipeline for one DONE cycle with the load result available.
module dmem_access_ctrl #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              isMemRead_EX_MEM,
  input  logic              isMemWrite_EX_MEM,
  input  logic              isNotHalt_EX_MEM,
  input  logic [ADDR_W-1:0] ALURes_EX_MEM,
  input  logic [DATA_W-1:0] rdData2_EX_MEM,
  dmem_access_ctrl_if.master mem,
  output logic              pipe_en,
  output logic              mem_bubble,
  output logic [DATA_W-1:0] ld_data,
  output logic              err
);

  // Counter only has to reach TIMEOUT-1 and is cleared on every issue.
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             is_rd_reg;
  logic             go;
  logic             conflict;

  // A legal access needs exactly one of read/write and no halt; both set is
  // a malformed instruction that is flagged and let through as a no-op.
  assign go       = isNotHalt_EX_MEM & (isMemRead_EX_MEM ^ isMemWrite_EX_MEM);
  assign conflict = isNotHalt_EX_MEM & isMemRead_EX_MEM & isMemWrite_EX_MEM;

  // Pipeline enable must drop in the issue cycle itself, so it is decoded
  // from the current state and the EX/MEM inputs rather than registered.
  always_comb begin
    pipe_en = 1'b0;
    case (state_reg)
      IDLE:    pipe_en = ~go;
      DONE:    pipe_en = 1'b1;
      default: pipe_en = 1'b0;
    endcase
    mem_bubble = ~pipe_en;
  end

  // Access sequencer: request pulses, latched address/data, wait counter,
  // load capture and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      is_rd_reg      <= 1'b0;
      mem.mem_rd     <= 1'b0;
      mem.mem_wr     <= 1'b0;
      mem.mem_addr   <= '0;
      mem.mem_wdata  <= '0;
      ld_data        <= '0;
      err            <= 1'b0;
    end else begin
      // Requests are one-cycle pulses; only the issue branch raises them.
      mem.mem_rd <= 1'b0;
      mem.mem_wr <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (go) begin
            mem.mem_rd    <= isMemRead_EX_MEM;
            mem.mem_wr    <= isMemWrite_EX_MEM;
            mem.mem_addr  <= ALURes_EX_MEM;
            mem.mem_wdata <= rdData2_EX_MEM;
            is_rd_reg     <= isMemRead_EX_MEM;
            cnt_reg       <= '0;
            state_reg     <= WAIT;
          end else if (conflict) begin
            err <= 1'b1;
          end
        end
        WAIT: begin
          if (mem.mem_done) begin
            if (is_rd_reg) begin
              ld_data <= mem.mem_rdata;
            end
            state_reg <= DONE;
          end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
            // Abort; IDLE re-evaluates the still-frozen instruction.
            err       <= 1'b1;
            state_reg <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: directed scenarios followed by randomized
// memory instructions, checked cycle by cycle against a transaction-level
// model of the expected pipeline freeze length, request pulses and results.
module tb_dmem_access_ctrl;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 16;
  localparam int TIMEOUT = 4;

  logic              clk;
  logic              rst;
  logic              rd_i;
  logic              wr_i;
  logic              nh_i;
  logic [ADDR_W-1:0] alu_i;
  logic [DATA_W-1:0] rd2_i;
  logic              pipe_en;
  logic              mem_bubble;
  logic [DATA_W-1:0] ld_data;
  logic              err;

  dmem_access_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dmem_access_ctrl #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .isMemRead_EX_MEM (rd_i),
    .isMemWrite_EX_MEM(wr_i),
    .isNotHalt_EX_MEM (nh_i),
    .ALURes_EX_MEM    (alu_i),
    .rdData2_EX_MEM   (rd2_i),
    .mem              (bus),
    .pipe_en          (pipe_en),
    .mem_bubble       (mem_bubble),
    .ld_data          (ld_data),
    .err              (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int txn    = 0;

  // Model state: sticky error and the last load result.
  logic              exp_err;
  logic [DATA_W-1:0] exp_ld;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s txn=%0d observed=%0h expected=%0h", tag, txn, obs, exp_v);
    end
  endtask

  task automatic drive(input bit rd, input bit wr, input bit nh,
                       input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
    rd_i  = rd;
    wr_i  = wr;
    nh_i  = nh;
    alu_i = addr;
    rd2_i = wdata;
  endtask

  // One EX/MEM instruction. For memory ops: n_to aborted attempts, then an
  // attempt answered in its k-th WAIT cycle (1 <= k <= TIMEOUT).
  task automatic mem_op(input bit rd, input bit wr, input bit nh,
                        input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                        input int k, input int n_to, input logic [DATA_W-1:0] rdata);
    bit go;
    int len;
    txn++;
    go = nh && (rd ^ wr);
    $display("txn %0d: rd=%0d wr=%0d nothalt=%0d addr=%h wdata=%h k=%0d timeouts=%0d rdata=%h",
             txn, rd, wr, nh, addr, wdata, k, n_to, rdata);
    if (!go) begin
      @(negedge clk);
      drive(rd, wr, nh, addr, wdata);
      bus.mem_done  = 1'($urandom);
      bus.mem_rdata = DATA_W'($urandom);
      #1;
      check("idle_pipe_en", pipe_en, 1);
      check("idle_bubble", mem_bubble, 0);
      check("idle_rd", bus.mem_rd, 0);
      check("idle_wr", bus.mem_wr, 0);
      check("idle_err", err, exp_err);
      check("idle_ld", ld_data, exp_ld);
      if (nh && rd && wr) exp_err = 1'b1;
      return;
    end
    for (int a = 0; a <= n_to; a++) begin
      len = (a < n_to) ? TIMEOUT : k;
      for (int c = 0; c <= len; c++) begin
        @(negedge clk);
        drive(rd, wr, nh, addr, wdata);
        bus.mem_done  = (a == n_to) && (c == k);
        bus.mem_rdata = bus.mem_done ? rdata : DATA_W'($urandom);
        #1;
        check("busy_pipe_en", pipe_en, 0);
        check("busy_bubble", mem_bubble, 1);
        check("req_rd", bus.mem_rd, (c == 1) && rd);
        check("req_wr", bus.mem_wr, (c == 1) && wr);
        check("busy_err", err, exp_err);
        if (c >= 1) begin
          check("req_addr", bus.mem_addr, addr);
          check("req_wdata", bus.mem_wdata, wdata);
        end
      end
      if (a < n_to) exp_err = 1'b1;
    end
    if (rd) exp_ld = rdata;
    // DONE cycle: pipeline released, result visible; a stray done is ignored.
    @(negedge clk);
    bus.mem_done  = 1'($urandom);
    bus.mem_rdata = DATA_W'($urandom);
    #1;
    check("done_pipe_en", pipe_en, 1);
    check("done_bubble", mem_bubble, 0);
    check("done_ld", ld_data, exp_ld);
    check("done_rd", bus.mem_rd, 0);
    check("done_wr", bus.mem_wr, 0);
    check("done_err", err, exp_err);
  endtask

  initial begin
    int op;
    rst = 1'b1;
    drive(0, 0, 1, '0, '0);
    bus.mem_done  = 1'b0;
    bus.mem_rdata = '0;
    exp_err = 1'b0;
    exp_ld  = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    check("rst_rd", bus.mem_rd, 0);
    check("rst_wr", bus.mem_wr, 0);
    check("rst_addr", bus.mem_addr, 0);
    check("rst_wdata", bus.mem_wdata, 0);
    check("rst_ld", ld_data, 0);
    check("rst_err", err, 0);
    check("rst_pipe_en", pipe_en, 1);
    check("rst_bubble", mem_bubble, 0);
    rst = 1'b0;

    // Non-memory instructions and halt with a read flag.
    repeat (3) mem_op(0, 0, 1, 16'h1111, 16'h2222, 1, 0, 16'h0);
    mem_op(1, 0, 0, 16'h0040, 16'h0, 1, 0, 16'h0);
    mem_op(0, 1, 0, 16'h0040, 16'h0, 1, 0, 16'h0);

    // Load with done in 2nd WAIT cycle, store with done in 1st.
    mem_op(1, 0, 1, 16'h0040, 16'h0000, 2, 0, 16'hBEEF);
    mem_op(0, 1, 1, 16'h0010, 16'h1234, 1, 0, 16'h5A5A);

    // One timeout, then completion with err still set.
    mem_op(1, 0, 1, 16'h0080, 16'h0, 3, 1, 16'hCAFE);

    // Read+write conflict: flagged, passed through.
    mem_op(1, 1, 1, 16'h0099, 16'h0, 1, 0, 16'h0);
    mem_op(0, 0, 1, 16'h0000, 16'h0, 1, 0, 16'h0);

    // Back-to-back loads.
    mem_op(1, 0, 1, 16'h0002, 16'h0, 1, 0, 16'h0A0A);
    mem_op(1, 0, 1, 16'h0004, 16'h0, 3, 0, 16'h0B0B);

    // Randomized instruction stream.
    for (int i = 0; i < 40; i++) begin
      op = int'($urandom_range(0, 7));
      case (op)
        0, 1, 2: mem_op(1, 0, 1, ADDR_W'($urandom), DATA_W'($urandom),
                        int'($urandom_range(1, TIMEOUT)), ($urandom_range(0, 7) == 0) ? 1 : 0,
                        DATA_W'($urandom));
        3, 4:    mem_op(0, 1, 1, ADDR_W'($urandom), DATA_W'($urandom),
                        int'($urandom_range(1, TIMEOUT)), ($urandom_range(0, 7) == 0) ? 1 : 0,
                        DATA_W'($urandom));
        5:       mem_op(0, 0, 1, ADDR_W'($urandom), DATA_W'($urandom), 1, 0, '0);
        6:       mem_op(1'($urandom), 1'($urandom), 0, ADDR_W'($urandom), DATA_W'($urandom), 1, 0, '0);
        default: mem_op(1, 1, 1, ADDR_W'($urandom), DATA_W'($urandom), 1, 0, '0);
      endcase
    end

    // Reset in the 2nd WAIT cycle of a load, then a late mem_done.
    txn++;
    $display("txn %0d: load at 00aa interrupted by reset in 2nd WAIT cycle", txn);
    @(negedge clk);
    drive(1, 0, 1, 16'h00AA, 16'h0000);
    bus.mem_done = 1'b0;
    #1;
    check("rw_issue_pipe_en", pipe_en, 0);
    @(negedge clk);
    #1;
    check("rw_req_rd", bus.mem_rd, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rw_wait2_pipe_en", pipe_en, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 1, 16'h0000, 16'h0000);
    bus.mem_done  = 1'b1;
    bus.mem_rdata = 16'hDEAD;
    #1;
    exp_err = 1'b0;
    exp_ld  = '0;
    check("rw_rst_rd", bus.mem_rd, 0);
    check("rw_rst_wr", bus.mem_wr, 0);
    check("rw_rst_addr", bus.mem_addr, 0);
    check("rw_rst_wdata", bus.mem_wdata, 0);
    check("rw_rst_ld", ld_data, exp_ld);
    check("rw_rst_err", err, exp_err);
    check("rw_rst_pipe_en", pipe_en, 1);
    check("rw_rst_bubble", mem_bubble, 0);
    @(negedge clk);
    bus.mem_done = 1'b0;
    #1;
    check("rw_after_ld", ld_data, exp_ld);
    check("rw_after_pipe_en", pipe_en, 1);
    check("rw_after_rd", bus.mem_rd, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
